// File: rtl/zion_riscv_isa_lib_slt_share_arb.sv
// Shared set-less-than comparator: round-robin grant of NUM_REQ operand channels
// into one compare stage, result held in a single-entry response slot with backpressure.
module zion_riscv_isa_lib_slt_share_arb #(
    parameter  int RV64      = 0,
    parameter  int NUM_REQ   = 2,
    parameter  int TAG_W     = 4,
    localparam int CPU_WIDTH = (RV64 != 0) ? 64 : 32,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           iClk,
    input  logic                           iRst_n,
    input  logic [NUM_REQ-1:0]             iReqVld,
    output logic [NUM_REQ-1:0]             oReqRdy,
    input  logic [NUM_REQ-1:0]             iReqUnsigned,
    input  logic [NUM_REQ*CPU_WIDTH-1:0]   iReqS1,
    input  logic [NUM_REQ*CPU_WIDTH-1:0]   iReqS2,
    input  logic [NUM_REQ*TAG_W-1:0]       iReqTag,
    input  logic                           iFlush,
    output logic [NUM_REQ-1:0]             oRspVld,
    input  logic [NUM_REQ-1:0]             iRspRdy,
    output logic                           oRspRslt,
    output logic [TAG_W-1:0]               oRspTag,
    output logic [31:0]                    oCmpCnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t          state_reg;
    logic [IDX_W-1:0]     ptr_reg;
    logic [IDX_W-1:0]     owner_reg;
    logic                 rslt_reg;
    logic [TAG_W-1:0]     tag_reg;
    logic [31:0]          cmp_cnt_reg;

    logic [NUM_REQ-1:0]   rsp_vld;
    logic                 rsp_fire;
    logic                 slot_free;
    logic                 grant_en;
    logic                 grant_any;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     ptr_next;
    logic [31:0]          cmp_cnt_next;

    logic [IDX_W-1:0]     cand_idx [NUM_REQ];
    logic [CPU_WIDTH-1:0] s1_arr   [NUM_REQ];
    logic [CPU_WIDTH-1:0] s2_arr   [NUM_REQ];
    logic [TAG_W-1:0]     tag_arr  [NUM_REQ];

    logic [CPU_WIDTH-1:0] sel_s1;
    logic [CPU_WIDTH-1:0] sel_s2;
    logic                 sel_uns;
    logic [TAG_W-1:0]     sel_tag;
    logic signed [CPU_WIDTH:0] ext_s1;
    logic signed [CPU_WIDTH:0] ext_s2;
    logic                 cmp_lt;

    // Per-requester unpacking; cand_idx[k] is the k-th requester in search order from ptr.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [IDX_W:0] cand_sum;

            assign s1_arr[gi]  = iReqS1[gi*CPU_WIDTH +: CPU_WIDTH];
            assign s2_arr[gi]  = iReqS2[gi*CPU_WIDTH +: CPU_WIDTH];
            assign tag_arr[gi] = iReqTag[gi*TAG_W +: TAG_W];

            assign cand_sum     = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum >= (IDX_W+1)'(NUM_REQ))
                                ? IDX_W'(cand_sum - (IDX_W+1)'(NUM_REQ))
                                : cand_sum[IDX_W-1:0];

            assign rsp_vld[gi] = (state_reg == FULL) && (owner_reg == IDX_W'(gi));
            assign oReqRdy[gi] = grant_any && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    assign rsp_fire  = |(rsp_vld & iRspRdy);
    assign slot_free = (state_reg == EMPTY) || rsp_fire;
    assign grant_en  = slot_free && !iFlush;

    // Walk the search order backwards so the candidate closest to ptr is the last writer.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (grant_en) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (iReqVld[cand_idx[k]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx[k];
                end
            end
        end
    end

    assign sel_s1  = s1_arr[grant_idx];
    assign sel_s2  = s2_arr[grant_idx];
    assign sel_uns = iReqUnsigned[grant_idx];
    assign sel_tag = tag_arr[grant_idx];

    // One extra MSB makes a single signed compare serve both SLT and SLTU.
    assign ext_s1 = {~sel_uns & sel_s1[CPU_WIDTH-1], sel_s1};
    assign ext_s2 = {~sel_uns & sel_s2[CPU_WIDTH-1], sel_s2};
    assign cmp_lt = (ext_s1 < ext_s2);

    assign ptr_next     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign cmp_cnt_next = (cmp_cnt_reg == 32'hFFFF_FFFF) ? cmp_cnt_reg : cmp_cnt_reg + 32'd1;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_reg   <= EMPTY;
            ptr_reg     <= '0;
            owner_reg   <= '0;
            rslt_reg    <= 1'b0;
            tag_reg     <= '0;
            cmp_cnt_reg <= '0;
        end else begin
            if (iFlush) begin
                state_reg <= EMPTY;
            end else if (grant_any) begin
                state_reg <= FULL;
                owner_reg <= grant_idx;
                rslt_reg  <= cmp_lt;
                tag_reg   <= sel_tag;
            end else if (rsp_fire) begin
                state_reg <= EMPTY;
            end

            if (grant_any) begin
                ptr_reg <= ptr_next;
            end

            // A result discarded by flush is never counted as delivered.
            if (rsp_fire && !iFlush) begin
                cmp_cnt_reg <= cmp_cnt_next;
            end
        end
    end

    assign oRspVld  = rsp_vld;
    assign oRspRslt = rslt_reg;
    assign oRspTag  = tag_reg;
    assign oCmpCnt  = cmp_cnt_reg;

endmodule

// File: tb/tb_zion_riscv_isa_lib_slt_share_arb.sv
// Scoreboard bench: an RV32 and an RV64 instance, directed vectors push expected
// responses into queues that a negedge monitor pops on each delivered result.
module tb_zion_riscv_isa_lib_slt_share_arb;

    typedef struct packed {
        logic [1:0] vld;
        logic       rslt;
        logic [3:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // RV32 instance signals
    logic [1:0]   vld32, rdy32, uns32, rspvld32, rsprdy32;
    logic [63:0]  s1_32, s2_32;
    logic [7:0]   tag32;
    logic         flush32, rslt32;
    logic [3:0]   rtag32;
    logic [31:0]  cnt32;

    // RV64 instance signals
    logic [1:0]   vld64, rdy64, uns64, rspvld64, rsprdy64;
    logic [127:0] s1_64, s2_64;
    logic [7:0]   tag64;
    logic         flush64, rslt64;
    logic [3:0]   rtag64;
    logic [31:0]  cnt64;

    exp_t q32[$];
    exp_t q64[$];
    int checks = 0;
    int errors = 0;
    int exp_cnt32 = 0;

    zion_riscv_isa_lib_slt_share_arb #(.RV64(0), .NUM_REQ(2), .TAG_W(4)) d32 (
        .iClk(clk), .iRst_n(rst_n),
        .iReqVld(vld32), .oReqRdy(rdy32), .iReqUnsigned(uns32),
        .iReqS1(s1_32), .iReqS2(s2_32), .iReqTag(tag32),
        .iFlush(flush32), .oRspVld(rspvld32), .iRspRdy(rsprdy32),
        .oRspRslt(rslt32), .oRspTag(rtag32), .oCmpCnt(cnt32)
    );

    zion_riscv_isa_lib_slt_share_arb #(.RV64(1), .NUM_REQ(2), .TAG_W(4)) d64 (
        .iClk(clk), .iRst_n(rst_n),
        .iReqVld(vld64), .oReqRdy(rdy64), .iReqUnsigned(uns64),
        .iReqS1(s1_64), .iReqS2(s2_64), .iReqTag(tag64),
        .iFlush(flush64), .oRspVld(rspvld64), .iRspRdy(rsprdy64),
        .oRspRslt(rslt64), .oRspTag(rtag64), .oCmpCnt(cnt64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: compare every delivered (non-flushed) result against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (((rspvld32 & rsprdy32) != 2'b00) && !flush32) begin
                if (q32.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp32_unexpected actual=%b required=none", rspvld32);
                end else begin
                    e = q32.pop_front();
                    chk("rsp32_vld", rspvld32, e.vld);
                    chk("rsp32_rslt", rslt32, e.rslt);
                    chk("rsp32_tag", rtag32, e.tag);
                    $display("rsp32 owner=%b rslt=%0d tag=%0h cnt=%0d", rspvld32, rslt32, rtag32, cnt32);
                end
            end
            if (((rspvld64 & rsprdy64) != 2'b00) && !flush64) begin
                if (q64.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp64_unexpected actual=%b required=none", rspvld64);
                end else begin
                    e = q64.pop_front();
                    chk("rsp64_vld", rspvld64, e.vld);
                    chk("rsp64_rslt", rslt64, e.rslt);
                    chk("rsp64_tag", rtag64, e.tag);
                    $display("rsp64 owner=%b rslt=%0d tag=%0h", rspvld64, rslt64, rtag64);
                end
            end
        end
    end

    // One request from one requester; checks the same-cycle grant and queues the expected result.
    task automatic issue(input int d, input int idx, input logic [63:0] a, input logic [63:0] b,
                         input logic u, input logic [3:0] t, input logic e);
        exp_t x;
        logic [1:0] oh;
        oh = 2'b01 << idx;
        if (d == 0) begin
            vld32 = oh; uns32[idx] = u; tag32[idx*4 +: 4] = t;
            s1_32[idx*32 +: 32] = a[31:0]; s2_32[idx*32 +: 32] = b[31:0];
        end else begin
            vld64 = oh; uns64[idx] = u; tag64[idx*4 +: 4] = t;
            s1_64[idx*64 +: 64] = a; s2_64[idx*64 +: 64] = b;
        end
        @(negedge clk);
        x.vld = oh; x.rslt = e; x.tag = t;
        if (d == 0) begin
            chk("req32_rdy", rdy32, oh);
            q32.push_back(x);
            exp_cnt32++;
        end else begin
            chk("req64_rdy", rdy64, oh);
            q64.push_back(x);
        end
        $display("req dut=%0d idx=%0d s1=%h s2=%h uns=%0d tag=%0h", d, idx, a, b, u, t);
        @(posedge clk); #1;
        if (d == 0) vld32 = 2'b00; else vld64 = 2'b00;
    endtask

    initial begin
        exp_t x;
        vld32 = '0; uns32 = '0; s1_32 = '0; s2_32 = '0; tag32 = '0; flush32 = 1'b0; rsprdy32 = 2'b11;
        vld64 = '0; uns64 = '0; s1_64 = '0; s2_64 = '0; tag64 = '0; flush64 = 1'b0; rsprdy64 = 2'b11;

        #2;
        chk("rst_rdy", rdy32, 2'b00);
        chk("rst_rspvld", rspvld32, 2'b00);
        chk("rst_rslt", rslt32, 1'b0);
        chk("rst_tag", rtag32, 4'h0);
        chk("rst_cnt", cnt32, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rspvld", rspvld32, 2'b00);
        chk("post_rst_cnt", cnt32, 32'd0);
        @(posedge clk); #1;

        // Round robin: both valid, grants alternate starting at requester 0
        vld32 = 2'b11; uns32 = 2'b00;
        s1_32 = {32'd2, 32'd1}; s2_32 = {32'd1, 32'd2}; tag32 = {4'hB, 4'hA};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            x.vld  = (i % 2 == 0) ? 2'b01 : 2'b10;
            x.rslt = (i % 2 == 0) ? 1'b1 : 1'b0;
            x.tag  = (i % 2 == 0) ? 4'hA : 4'hB;
            chk("rr_grant", rdy32, x.vld);
            q32.push_back(x);
            exp_cnt32++;
            $display("rr cycle=%0d grant=%b", i, rdy32);
            @(posedge clk); #1;
        end
        vld32 = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rr_cnt", cnt32, 32'd8);
        @(posedge clk); #1;

        // RV32 signed/unsigned vectors
        issue(0, 0, 64'hFFFF_FFFF, 64'h1,         1'b0, 4'h3, 1'b1);
        issue(0, 0, 64'hFFFF_FFFF, 64'h1,         1'b1, 4'h4, 1'b0);
        issue(0, 1, 64'h5,         64'hFFFF_FFFE, 1'b0, 4'h5, 1'b0);
        issue(0, 1, 64'h5,         64'hFFFF_FFFE, 1'b1, 4'h6, 1'b1);
        issue(0, 0, 64'h8000_0000, 64'h7FFF_FFFF, 1'b0, 4'h7, 1'b1);
        issue(0, 1, 64'h1234,      64'h1234,      1'b1, 4'h8, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;

        // Backpressure: result held for 3 cycles, then same-cycle grant on release
        rsprdy32 = 2'b00;
        vld32 = 2'b01; uns32 = 2'b00; s1_32[31:0] = 32'd3; s2_32[31:0] = 32'd7; tag32[3:0] = 4'hC;
        @(negedge clk);
        chk("bp_grant0", rdy32, 2'b01);
        x.vld = 2'b01; x.rslt = 1'b1; x.tag = 4'hC;
        q32.push_back(x); exp_cnt32++;
        @(posedge clk); #1;
        vld32 = 2'b10; s1_32[63:32] = 32'd9; s2_32[63:32] = 32'd4; tag32[7:4] = 4'hD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rdy", rdy32, 2'b00);
            chk("bp_rspvld", rspvld32, 2'b01);
            chk("bp_rslt", rslt32, 1'b1);
            chk("bp_tag", rtag32, 4'hC);
            $display("bp hold cycle=%0d rdy=%b rspvld=%b", k, rdy32, rspvld32);
            @(posedge clk); #1;
        end
        rsprdy32 = 2'b11;
        @(negedge clk);
        chk("bp_release_grant", rdy32, 2'b10);
        x.vld = 2'b10; x.rslt = 1'b0; x.tag = 4'hD;
        q32.push_back(x); exp_cnt32++;
        @(posedge clk); #1;
        vld32 = 2'b00;
        @(negedge clk);
        @(posedge clk); #1;

        // Flush with slot full and response ready: discarded, uncounted, no grant
        vld32 = 2'b01; uns32 = 2'b11; s1_32[31:0] = 32'd4; s2_32[31:0] = 32'd5; tag32[3:0] = 4'hE;
        @(negedge clk);
        chk("fl_grant", rdy32, 2'b01);
        x.vld = 2'b01; x.rslt = 1'b1; x.tag = 4'hE;
        q32.push_back(x); exp_cnt32++;
        @(posedge clk); #1;
        flush32 = 1'b1; s1_32[31:0] = 32'd0; s2_32[31:0] = 32'd1; tag32[3:0] = 4'hF;
        @(negedge clk);
        chk("fl_no_grant", rdy32, 2'b00);
        void'(q32.pop_back());
        exp_cnt32--;
        $display("flush rdy=%b rspvld=%b", rdy32, rspvld32);
        @(posedge clk); #1;
        flush32 = 1'b0; vld32 = 2'b00;
        @(negedge clk);
        chk("fl_rspvld", rspvld32, 2'b00);
        chk("fl_cnt", cnt32, 32'(exp_cnt32));

        // Saturation of the delivered-result counter
        force d32.cmp_cnt_reg = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release d32.cmp_cnt_reg;
        @(negedge clk);
        chk("sat_preset", cnt32, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        issue(0, 0, 64'h2, 64'h1, 1'b0, 4'h1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("sat_reach", cnt32, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        issue(0, 1, 64'h1, 64'h2, 1'b0, 4'h2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("sat_hold", cnt32, 32'hFFFF_FFFF);
        @(posedge clk); #1;

        // RV64 boundary vectors
        issue(1, 0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'h1, 1'b1);
        issue(1, 0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'h2, 1'b0);
        issue(1, 1, 64'h5,                   64'h5,                   1'b0, 4'h3, 1'b0);
        issue(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1'b0, 4'h4, 1'b1);
        issue(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1'b1, 4'h5, 1'b0);
        issue(1, 1, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 4'h6, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;

        // Reset while full: response valid drops immediately
        rsprdy32 = 2'b00;
        issue(0, 0, 64'h1, 64'h2, 1'b0, 4'h9, 1'b1);
        @(negedge clk);
        chk("mid_rst_full", rspvld32, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rspvld", rspvld32, 2'b00);
        chk("mid_rst_rslt", rslt32, 1'b0);
        chk("mid_rst_cnt", cnt32, 32'd0);
        void'(q32.pop_back());
        exp_cnt32 = 0;
        $display("reset asserted rspvld=%b cnt=%0d", rspvld32, cnt32);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsprdy32 = 2'b11;
        @(negedge clk);
        chk("post_mid_rst_rspvld", rspvld32, 2'b00);

        repeat (2) @(posedge clk);
        #1;
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zion_riscv_isa_lib_slt_share_arb.md
# zion_riscv_isa_lib_slt_share_arb

Shares a single set-less-than comparator between `NUM_REQ` requesters, such as the ALU SLT/SLTI/SLTU/SLTIU path and the branch-condition path (BLT/BGE/BLTU/BGEU).
- Each requester presents operands over a valid/ready channel.
- A round-robin arbiter grants one request per cycle into the shared compare stage.
- The 1-bit result is returned to the owner through a registered single-entry response slot with backpressure.
- Sits in the Ex stage between the issue logic and the SLT datapath.

## Interface
Parameters:
- `RV64`, 0, 1 selects RV64 (`CPU_WIDTH` = 64); 0 selects RV32 (`CPU_WIDTH` = 32).
- `NUM_REQ`, 2, number of requesters, 2..8.
- `TAG_W`, 4, width of the opaque tag returned with each result.

Ports:
- `iClk`  in  1  clock, rising edge.
- `iRst_n`  in  1  reset, asynchronous, active-low.
- `iReqVld`  in  `NUM_REQ`  per-requester request valid.
- `oReqRdy`  out  `NUM_REQ`  per-requester accept; one-hot or zero.
- `iReqUnsigned`  in  `NUM_REQ`  1 selects unsigned compare (SLTU/BLTU class).
- `iReqS1`  in  `NUM_REQ*CPU_WIDTH`  operand 1; requester i occupies slice i.
- `iReqS2`  in  `NUM_REQ*CPU_WIDTH`  operand 2; same packing as `iReqS1`.
- `iReqTag`  in  `NUM_REQ*TAG_W`  tag per requester.
- `iFlush`  in  1  discard the held result and block grants this cycle.
- `oRspVld`  out  `NUM_REQ`  one-hot result valid, addressed to the owning requester.
- `iRspRdy`  in  `NUM_REQ`  per-requester result accept.
- `oRspRslt`  out  1  compare result: 1 iff s1 < s2.
- `oRspTag`  out  `TAG_W`  tag of the held result.
- `oCmpCnt`  out  32  saturating count of delivered results.

## Operation
- The response slot has two states: EMPTY (reset state) and FULL.
- `rspFire` = (`oRspVld` & `iRspRdy`) != 0.
- `slotFree` = EMPTY, or FULL with `rspFire`.
- Arbitration:
  - When `slotFree` and not `iFlush`, grant the first requester with `iReqVld` set, searching from `ptr` upward with wrap.
  - `oReqRdy[g]` = 1 for the granted requester only, combinationally in the same cycle.
  - No grant occurs when no request is valid.
- Round-robin pointer:
  - `ptr` resets to 0.
  - After a grant to g, `ptr` becomes (g+1) mod `NUM_REQ`.
  - Otherwise `ptr` holds.
- Compare:
  - Each operand is extended to `CPU_WIDTH`+1 bits with MSB = ~unsigned & operand MSB, then compared as signed.
  - The result (s1 < s2) is registered in the grant cycle together with the tag and the owner index.
- State transitions:
  - EMPTY plus grant → FULL.
  - FULL with `rspFire` and no grant → EMPTY.
  - FULL with `rspFire` and a grant → FULL (back-to-back, new contents).
  - FULL without `rspFire` → hold all contents.
  - `iFlush` → EMPTY, overriding every other event.
- `oRspVld` = FULL ? one-hot(owner) : 0. `oRspRslt` and `oRspTag` reflect the held contents.
- `oCmpCnt` increments on `rspFire` only and saturates at 0xFFFFFFFF. A flushed result is not counted.
- A requester must hold `iReqVld` and its operands stable until `oReqRdy` is seen. Dropping valid before the grant is allowed; the request is simply not granted.

## Timing
- Reset values:
  - `oReqRdy` = 0, `oRspVld` = 0, `oRspRslt` = 0, `oRspTag` = 0, `oCmpCnt` = 0.
  - State = EMPTY, `ptr` = 0.
- Latency: request accepted in cycle N, result valid in cycle N+1.
- Throughput: one result per cycle when the owner holds `iRspRdy` = 1.
- Backpressure: while FULL and not accepted, `oReqRdy` = 0 for all requesters.
- Simultaneous flush and response-ready: the flush wins, and the result is discarded and not counted.
- Reset asserted mid-operation: all state clears asynchronously, and a pending result is lost.

## Test plan
- RV32, signed and unsigned compare:
  - Req0 with s1 = 0xFFFFFFFF, s2 = 1, unsigned = 0, tag = 3 → `oReqRdy` = 01; next cycle `oRspVld` = 01, `oRspRslt` = 1, `oRspTag` = 3.
  - Same operands with unsigned = 1 → `oRspRslt` = 0.
- Round-robin fairness:
  - Both requesters valid continuously with `iRspRdy` = 11 → grants alternate 0,1,0,1 for 8 cycles.
  - `oCmpCnt` = 8 after the last result is accepted.
- Backpressure:
  - Hold `iRspRdy` = 0 for 3 cycles after a result is produced → `oReqRdy` = 00 throughout, and the result and tag stay stable.
  - Raising `iRspRdy` then gives a same-cycle grant of the next request.
- Flush:
  - Assert `iFlush` with the slot FULL and `iRspRdy` = 1 → the next cycle shows `oRspVld` = 0 and `oCmpCnt` unchanged.
  - No grant occurs during the flush cycle.
- RV64 boundary:
  - s1 = 0x8000000000000000, s2 = 0x7FFFFFFFFFFFFFFF, signed → result 1; unsigned → result 0.
  - s1 = s2 → result 0.
- Reset and saturation:
  - Assert `iRst_n` = 0 while FULL → `oRspVld` = 0 immediately.
  - Force the counter to 0xFFFFFFFF and deliver one result → `oCmpCnt` stays 0xFFFFFFFF.
